// File: rtl/mux_stream_pkg.sv
// Shared definitions for the streaming round-robin multiplexer.
package mux_stream_pkg;

  // Selection modes
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Ceiling log2, used at elaboration time to validate the select width
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/mux_stream_rr_arbiter.sv
// Combinational round-robin arbiter: rotates the request vector so the
// pointer position lands on bit 0, picks the lowest set bit, then adds the
// pointer back (mod NrOfChannels) to recover the absolute channel index.
module rr_arbiter
  import mux_stream_pkg::*;
#(
  parameter int NrOfChannels = 32,
  parameter int SelBits      = 5
) (
  input  logic [NrOfChannels-1:0] request,
  input  logic [SelBits-1:0]      pointer,
  output logic [SelBits-1:0]      grantIdx,
  output logic                    grantValid
);

  localparam logic [SelBits:0] ChanCount = (SelBits + 1)'(NrOfChannels);
  localparam logic [SelBits:0] ZeroWide  = {(SelBits + 1){1'b0}};

  logic [2*NrOfChannels-1:0] doubled_s;
  logic [NrOfChannels-1:0]   rotated_s;
  logic [SelBits:0]          safePtr_s;
  logic [SelBits:0]          offset_s;
  logic [SelBits:0]          sum_s;

  // Rotate-and-priority-encode; a pointer outside the channel range is
  // treated as 0 so the search can never run off the doubled vector
  always_comb begin
    safePtr_s  = {1'b0, pointer};
    doubled_s  = {request, request};
    rotated_s  = {NrOfChannels{1'b0}};
    offset_s   = ZeroWide;
    sum_s      = ZeroWide;
    grantIdx   = {SelBits{1'b0}};
    grantValid = |request;

    if (safePtr_s >= ChanCount) begin
      safePtr_s = ZeroWide;
    end else begin
      safePtr_s = {1'b0, pointer};
    end

    rotated_s = NrOfChannels'(doubled_s >> safePtr_s);

    // Scan downward so the lowest set bit is the last one written
    for (int i = NrOfChannels - 1; i >= 0; i--) begin
      if (rotated_s[i]) begin
        offset_s = (SelBits + 1)'(i);
      end else begin
        offset_s = offset_s;
      end
    end

    sum_s = safePtr_s + offset_s;
    if (sum_s >= ChanCount) begin
      sum_s = sum_s - ChanCount;
    end else begin
      sum_s = sum_s;
    end

    grantIdx = sum_s[SelBits-1:0];
  end

endmodule

// File: rtl/mux_stream_rr.sv
// N-channel streaming multiplexer with valid/ready on every input, a single
// registered output slot, and either fixed-select or round-robin arbitration.
module mux_stream_rr
  import mux_stream_pkg::*;
#(
  parameter int NrOfBits     = 32,
  parameter int NrOfChannels = 32,
  parameter int SelBits      = 5
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic                             Enable,
  input  logic                             Mode,
  input  logic [SelBits-1:0]               Sel,
  input  logic [NrOfChannels*NrOfBits-1:0] MuxIn,
  input  logic [NrOfChannels-1:0]          InValid,
  output logic [NrOfChannels-1:0]          InReady,
  output logic [NrOfBits-1:0]              MuxOut,
  output logic                             OutValid,
  input  logic                             OutReady,
  output logic [SelBits-1:0]               OutChan
);

  localparam logic [SelBits:0]   LastChan = (SelBits + 1)'(NrOfChannels - 1);
  localparam logic [SelBits-1:0] ZeroIdx  = {SelBits{1'b0}};

  generate
    if (NrOfChannels < 2 || NrOfChannels > 32) begin : gBadChannelCount
      $error("mux_stream_rr: NrOfChannels must be in 2..32");
    end
    if (SelBits < clog2(NrOfChannels)) begin : gBadSelBits
      $error("mux_stream_rr: SelBits too narrow for NrOfChannels");
    end
  endgenerate

  logic [SelBits-1:0]      rrPtr_r;
  logic [SelBits-1:0]      outChan_r;
  logic [NrOfBits-1:0]     muxOut_r;
  logic                    outValid_r;

  logic [SelBits-1:0]      rrGrant_s;
  logic                    rrValid_s;
  logic                    fixedValid_s;
  logic [SelBits-1:0]      grantIdx_s;
  logic                    grantValid_s;
  logic                    slotFree_s;
  logic                    accept_s;
  logic [NrOfChannels-1:0] inReady_s;
  logic [NrOfBits-1:0]     grantData_s;
  logic [SelBits-1:0]      nextPtr_s;

  rr_arbiter #(
    .NrOfChannels (NrOfChannels),
    .SelBits      (SelBits)
  ) uArbiter (
    .request    (InValid),
    .pointer    (rrPtr_r),
    .grantIdx   (rrGrant_s),
    .grantValid (rrValid_s)
  );

  // Fixed-select qualification: an out-of-range Sel matches no channel,
  // so it never grants and never indexes past the input vector
  always_comb begin
    fixedValid_s = 1'b0;
    for (int i = 0; i < NrOfChannels; i++) begin
      if (Sel == SelBits'(i)) begin
        fixedValid_s = InValid[i];
      end else begin
        fixedValid_s = fixedValid_s;
      end
    end
  end

  // Pick the grant source according to the selection mode
  always_comb begin
    grantIdx_s   = ZeroIdx;
    grantValid_s = 1'b0;
    case (Mode)
      MODE_FIXED: begin
        grantIdx_s   = Sel;
        grantValid_s = fixedValid_s;
      end
      MODE_RR: begin
        grantIdx_s   = rrGrant_s;
        grantValid_s = rrValid_s;
      end
      default: begin
        grantIdx_s   = ZeroIdx;
        grantValid_s = 1'b0;
      end
    endcase
  end

  // Handshake: accept when enabled, the slot is free (or draining this
  // cycle) and a grant exists; ready goes only to the granted channel
  always_comb begin
    slotFree_s  = ~outValid_r | OutReady;
    accept_s    = Enable & slotFree_s & grantValid_s & ~Reset;
    inReady_s   = {NrOfChannels{1'b0}};
    grantData_s = {NrOfBits{1'b0}};
    for (int i = 0; i < NrOfChannels; i++) begin
      if (grantIdx_s == SelBits'(i)) begin
        inReady_s[i] = accept_s;
        grantData_s  = MuxIn[i*NrOfBits +: NrOfBits];
      end else begin
        inReady_s[i] = 1'b0;
      end
    end
  end

  // Round-robin pointer advances to the channel after the winner, wrapping
  always_comb begin
    if ({1'b0, grantIdx_s} == LastChan) begin
      nextPtr_s = ZeroIdx;
    end else begin
      nextPtr_s = grantIdx_s + SelBits'(1'b1);
    end
  end

  // Output slot and pointer; data/channel hold their value when drained
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      muxOut_r   <= {NrOfBits{1'b0}};
      outChan_r  <= ZeroIdx;
      outValid_r <= 1'b0;
      rrPtr_r    <= ZeroIdx;
    end else if (accept_s) begin
      muxOut_r   <= grantData_s;
      outChan_r  <= grantIdx_s;
      outValid_r <= 1'b1;
      if (Mode == MODE_RR) begin
        rrPtr_r <= nextPtr_s;
      end
    end else if (OutReady && outValid_r) begin
      outValid_r <= 1'b0;
    end
  end

  assign InReady  = inReady_s;
  assign MuxOut   = muxOut_r;
  assign OutValid = outValid_r;
  assign OutChan  = outChan_r;

endmodule

// File: tb/tb_mux_stream_rr.sv
// Testbench for mux_stream_rr: directed checks on a 32-channel instance and
// a model/scoreboard-driven run on a 5-channel instance.
module tb_mux_stream_rr;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  // Instance A: 32 channels x 32 bits
  logic          EnableA, ModeA, OutReadyA, OutValidA;
  logic [4:0]    SelA, OutChanA;
  logic [1023:0] MuxInA;
  logic [31:0]   InValidA, InReadyA, MuxOutA;

  // Instance B: 5 channels x 16 bits, 3 select bits
  logic        EnableB, ModeB, OutReadyB, OutValidB;
  logic [2:0]  SelB, OutChanB;
  logic [79:0] MuxInB;
  logic [4:0]  InValidB, InReadyB;
  logic [15:0] MuxOutB;

  mux_stream_rr #(.NrOfBits(32), .NrOfChannels(32), .SelBits(5)) dutA (
    .Clock(Clock), .Reset(Reset), .Enable(EnableA), .Mode(ModeA), .Sel(SelA),
    .MuxIn(MuxInA), .InValid(InValidA), .InReady(InReadyA), .MuxOut(MuxOutA),
    .OutValid(OutValidA), .OutReady(OutReadyA), .OutChan(OutChanA)
  );

  mux_stream_rr #(.NrOfBits(16), .NrOfChannels(5), .SelBits(3)) dutB (
    .Clock(Clock), .Reset(Reset), .Enable(EnableB), .Mode(ModeB), .Sel(SelB),
    .MuxIn(MuxInB), .InValid(InValidB), .InReady(InReadyB), .MuxOut(MuxOutB),
    .OutValid(OutValidB), .OutReady(OutReadyB), .OutChan(OutChanB)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          chan;
    logic [15:0] data;
  } sbItem_t;

  sbItem_t sbQ[$];
  int      seqLog[$];
  int      mPtr = 0;
  logic    mValid = 1'b0;
  int      fairExp[6] = '{0, 1, 3, 0, 1, 3};
  int      wrapExp[4] = '{4, 0, 4, 0};

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic driveBData(input int s);
    for (int c = 0; c < 5; c++) begin
      MuxInB[c*16 +: 16] = 16'(c * 256 + s);
    end
  endtask

  // One cycle on instance B: check against the model, score output, update model
  task automatic stepB();
    logic    gv;
    int      g;
    int      c;
    logic    acc;
    logic [4:0] expReady;
    sbItem_t item;
    @(negedge Clock);
    gv = 1'b0;
    g  = 0;
    if (ModeB == 1'b0) begin
      if (SelB < 3'd5) begin
        gv = InValidB[SelB];
        g  = int'(SelB);
      end
    end else begin
      for (int k = 0; k < 5; k++) begin
        c = (mPtr + k) % 5;
        if (!gv && InValidB[c]) begin
          gv = 1'b1;
          g  = c;
        end
      end
    end
    acc = EnableB && (!mValid || OutReadyB) && gv;
    expReady = 5'b0;
    if (acc) expReady[g] = 1'b1;
    checkVal("B.ready", 64'(InReadyB), 64'(expReady));
    checkVal("B.valid", 64'(OutValidB), 64'(mValid));
    if (OutValidB && sbQ.size() > 0) begin
      checkVal("B.data", 64'(MuxOutB), 64'(sbQ[0].data));
      checkVal("B.chan", 64'(OutChanB), 64'(sbQ[0].chan));
      if (OutReadyB) begin
        item = sbQ.pop_front();
        seqLog.push_back(int'(OutChanB));
      end
    end
    if (acc) begin
      item.chan = g;
      item.data = MuxInB[g*16 +: 16];
      sbQ.push_back(item);
      mValid = 1'b1;
      if (ModeB) mPtr = (g == 4) ? 0 : g + 1;
    end else if (OutReadyB && mValid) begin
      mValid = 1'b0;
    end
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with everything requesting
    Reset = 1'b1;
    EnableA = 1'b1; ModeA = 1'b0; SelA = 5'd5; OutReadyA = 1'b1;
    InValidA = 32'hFFFF_FFFF;
    for (int i = 0; i < 32; i++) MuxInA[i*32 +: 32] = 32'h1000_0000 + 32'(i);
    MuxInA[5*32 +: 32] = 32'hDEAD_BEEF;
    MuxInA[9*32 +: 32] = 32'hC0FF_EE09;
    EnableB = 1'b1; ModeB = 1'b1; SelB = 3'd0; OutReadyB = 1'b1;
    InValidB = 5'b11111;
    driveBData(0);

    @(negedge Clock);
    checkVal("A.rstReady", 64'(InReadyA), 64'd0);
    checkVal("A.rstValid", 64'(OutValidA), 64'd0);
    checkVal("A.rstData", 64'(MuxOutA), 64'd0);
    checkVal("A.rstChan", 64'(OutChanA), 64'd0);
    checkVal("B.rstReady", 64'(InReadyB), 64'd0);
    tick();
    Reset = 1'b0;
    InValidB = 5'b00000;

    // Fixed select, channel 5
    @(negedge Clock);
    checkVal("A.fixReady", 64'(InReadyA), 64'h20);
    tick();
    @(negedge Clock);
    checkVal("A.fixData", 64'(MuxOutA), 64'hDEAD_BEEF);
    checkVal("A.fixChan", 64'(OutChanA), 64'd5);
    checkVal("A.fixValid", 64'(OutValidA), 64'd1);
    tick();
    SelA = 5'd7;
    InValidA[7] = 1'b0;
    @(negedge Clock);
    checkVal("A.sel7Ready", 64'(InReadyA), 64'd0);
    checkVal("A.sel7Valid", 64'(OutValidA), 64'd1);
    tick();
    @(negedge Clock);
    checkVal("A.drainValid", 64'(OutValidA), 64'd0);
    tick();

    // Back-pressure
    SelA = 5'd5;
    InValidA = 32'hFFFF_FFFF;
    OutReadyA = 1'b0;
    @(negedge Clock);
    checkVal("A.bpReady0", 64'(InReadyA), 64'h20);
    tick();
    MuxInA[5*32 +: 32] = 32'h1234_5678;
    @(negedge Clock);
    checkVal("A.bpReady1", 64'(InReadyA), 64'd0);
    checkVal("A.bpValid1", 64'(OutValidA), 64'd1);
    checkVal("A.bpData1", 64'(MuxOutA), 64'hDEAD_BEEF);
    checkVal("A.bpChan1", 64'(OutChanA), 64'd5);
    tick();
    SelA = 5'd9;
    @(negedge Clock);
    checkVal("A.bpReady2", 64'(InReadyA), 64'd0);
    checkVal("A.bpData2", 64'(MuxOutA), 64'hDEAD_BEEF);
    checkVal("A.bpChan2", 64'(OutChanA), 64'd5);
    tick();
    OutReadyA = 1'b1;
    @(negedge Clock);
    checkVal("A.popPushReady", 64'(InReadyA), 64'h200);
    tick();
    @(negedge Clock);
    checkVal("A.noBubbleValid", 64'(OutValidA), 64'd1);
    checkVal("A.noBubbleData", 64'(MuxOutA), 64'hC0FF_EE09);
    checkVal("A.noBubbleChan", 64'(OutChanA), 64'd9);
    tick();

    // Round-robin with Enable gap: pointer must survive the pause
    ModeA = 1'b1;
    InValidA = 32'h0010_0004;
    @(negedge Clock);
    checkVal("A.rrReady0", 64'(InReadyA), 64'h4);
    tick();
    EnableA = 1'b0;
    @(negedge Clock);
    checkVal("A.disReady", 64'(InReadyA), 64'd0);
    checkVal("A.disChan", 64'(OutChanA), 64'd2);
    tick();
    @(negedge Clock);
    checkVal("A.disDrain", 64'(OutValidA), 64'd0);
    checkVal("A.disReady2", 64'(InReadyA), 64'd0);
    tick();
    EnableA = 1'b1;
    @(negedge Clock);
    checkVal("A.resumeReady", 64'(InReadyA), 64'h0010_0000);
    tick();
    @(negedge Clock);
    checkVal("A.resumeChan", 64'(OutChanA), 64'd20);
    checkVal("A.resumeData", 64'(MuxOutA), 64'h1000_0014);
    tick();
    @(negedge Clock);
    checkVal("A.wrapChan", 64'(OutChanA), 64'd2);
    checkVal("A.wrapData", 64'(MuxOutA), 64'h1000_0002);
    tick();
    InValidA = 32'd0;

    // Instance B: fairness with channels 0,1,3
    ModeB = 1'b1; EnableB = 1'b1; OutReadyB = 1'b1;
    InValidB = 5'b01011;
    seqLog.delete();
    for (int s = 0; s < 7; s++) begin
      driveBData(s + 1);
      stepB();
    end
    checkVal("B.fairCount", 64'(seqLog.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < seqLog.size()) checkVal($sformatf("B.fair%0d", i), 64'(seqLog[i]), 64'(fairExp[i]));
    end
    InValidB = 5'b00000;
    stepB();

    // Wrap from channel 4 back to channel 0
    seqLog.delete();
    InValidB = 5'b10001;
    for (int s = 0; s < 5; s++) begin
      driveBData(s + 16);
      stepB();
    end
    checkVal("B.wrapCount", 64'(seqLog.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < seqLog.size()) checkVal($sformatf("B.wrap%0d", i), 64'(seqLog[i]), 64'(wrapExp[i]));
    end

    // Out-of-range fixed select never grants
    ModeB = 1'b0; SelB = 3'd6; InValidB = 5'b11111;
    stepB();
    checkVal("B.oorValid", 64'(OutValidB), 64'd0);
    stepB();

    // Randomised traffic against the model
    for (int n = 0; n < 300; n++) begin
      ModeB     = 1'($urandom_range(0, 1));
      SelB      = 3'($urandom_range(0, 7));
      InValidB  = 5'($urandom_range(0, 31));
      EnableB   = ($urandom_range(0, 9) < 8);
      OutReadyB = ($urandom_range(0, 9) < 7);
      for (int c = 0; c < 5; c++) MuxInB[c*16 +: 16] = 16'($urandom);
      stepB();
    end

    // Reset in the middle of a held transfer
    EnableB = 1'b1; ModeB = 1'b1; OutReadyB = 1'b1; InValidB = 5'b00000;
    stepB();
    OutReadyB = 1'b0; InValidB = 5'b11111;
    stepB();
    checkVal("B.heldBeforeRst", 64'(OutValidB), 64'd1);
    #2;
    Reset = 1'b1;
    #1;
    checkVal("B.asyncRstValid", 64'(OutValidB), 64'd0);
    checkVal("B.asyncRstData", 64'(MuxOutB), 64'd0);
    mValid = 1'b0;
    mPtr = 0;
    sbQ.delete();
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    OutReadyB = 1'b1;
    InValidB = 5'b00110;
    for (int s = 0; s < 3; s++) begin
      driveBData(s + 40);
      stepB();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
